// File: rtl/dmem_bist.sv
// Purpose: BIST initiator for the data memory; pattern and inverse-pattern write/read-compare.
// Latency: busy for exactly 4*NUM_WORDS cycles after start is accepted; done/pass registered at the end.
// Backpressure: none; memory reads are zero-latency and start is ignored while a test runs.
module dmem_bist #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned NUM_WORDS = 64,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] seed,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [31:0] first_fail_addr,
  output logic [31:0] first_fail_data
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR0  = 3'd1,
    RD0  = 3'd2,
    WR1  = 3'd3,
    RD1  = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] idx;
  logic [31:0] seed_q;
  logic        last;
  logic        accept;
  logic        in_test;
  logic        rd_phase;
  logic        mismatch;
  logic [31:0] pat;
  logic [31:0] expect_val;

  assign last     = (idx == LAST_IDX);
  assign accept   = ((state == IDLE) || (state == DONE)) && start;
  assign in_test  = (state == WR0) || (state == RD0) || (state == WR1) || (state == RD1);
  assign rd_phase = (state == RD0) || (state == RD1);
  assign pat      = seed_q + 32'(idx);

  // Phase sequencing: each test phase walks the whole window once, then hands over.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = WR0;
      WR0:     if (last)  state_nxt = RD0;
      RD0:     if (last)  state_nxt = WR1;
      WR1:     if (last)  state_nxt = RD1;
      RD1:     if (last)  state_nxt = DONE;
      DONE:    if (start) state_nxt = WR0;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; async reset makes mem_we drop immediately since it decodes from state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Memory port decode: pure function of state and idx, so no write can straddle a reset.
  always_comb begin
    mem_we     = 1'b0;
    mem_wd     = 32'd0;
    mem_a      = ADDR_BASE;
    expect_val = pat;
    if (in_test) mem_a = ADDR_BASE + 32'(idx) * ADDR_STEP;
    unique case (state)
      WR0: begin
        mem_we = 1'b1;
        mem_wd = pat;
      end
      WR1: begin
        mem_we = 1'b1;
        mem_wd = ~pat;
      end
      RD1:     expect_val = ~pat;
      default: ;
    endcase
  end

  assign mismatch = rd_phase && (mem_rd != expect_val);
  assign busy     = in_test;
  assign pass     = done && (err_count == 16'd0);

  // Word index and captured seed; idx wraps to 0 at the end of every phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= 16'd0;
      seed_q <= 32'd0;
    end else if (accept) begin
      idx    <= 16'd0;
      seed_q <= seed;
    end else if (in_test) begin
      idx <= last ? 16'd0 : idx + 16'd1;
    end
  end

  // Result tracking: saturating error count, first failing location, completion flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done            <= 1'b0;
      err_count       <= 16'd0;
      first_fail_addr <= 32'd0;
      first_fail_data <= 32'd0;
    end else if (accept) begin
      done            <= 1'b0;
      err_count       <= 16'd0;
      first_fail_addr <= 32'd0;
      first_fail_data <= 32'd0;
    end else begin
      if (mismatch) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == 16'd0) begin
          first_fail_addr <= mem_a;
          first_fail_data <= mem_rd;
        end
      end
      if ((state == RD1) && last) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_bist.sv
// Bench for dmem_bist: a 64-word instance at base 0 and a 4-word instance at a wrapping base.
// Memory models are behavioural arrays with an optional stuck-at bit applied on read.
// Results are compared against a direct computation of the write/read-compare sequence.
module tb_dmem_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start0, start1;
  logic [31:0] seed0, seed1;
  logic        mem_we0, mem_we1;
  logic [31:0] mem_a0, mem_wd0, mem_rd0, mem_a1, mem_wd1, mem_rd1;
  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic [15:0] err0, err1;
  logic [31:0] ffa0, ffd0, ffa1, ffd1;

  dmem_bist u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .seed(seed0),
    .mem_we(mem_we0), .mem_a(mem_a0), .mem_wd(mem_wd0), .mem_rd(mem_rd0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_addr(ffa0), .first_fail_data(ffd0)
  );

  dmem_bist #(.ADDR_BASE(32'hFFFF_FFF8), .NUM_WORDS(4), .ADDR_STEP(32'd4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .seed(seed1),
    .mem_we(mem_we1), .mem_a(mem_a1), .mem_wd(mem_wd1), .mem_rd(mem_rd1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_addr(ffa1), .first_fail_data(ffd1)
  );

  // Memory models
  logic [31:0] mem0 [64];
  logic [31:0] mem1 [4];
  bit          f_en, f_all, f_val;
  logic [5:0]  f_word;
  logic [4:0]  f_bit;
  logic [5:0]  widx0;
  logic [31:0] off1;
  logic [31:0] wr_log[$];
  logic [31:0] a1_log[$];

  assign widx0   = mem_a0[7:2];
  assign off1    = mem_a1 - 32'hFFFF_FFF8;
  assign mem_rd1 = mem1[off1[3:2]];

  always_comb begin
    mem_rd0 = mem0[widx0];
    if (f_en && (f_all || f_word == widx0)) mem_rd0[f_bit] = f_val;
  end

  always @(posedge clk) begin
    if (mem_we0) begin
      mem0[widx0] <= mem_wd0;
      wr_log.push_back(mem_a0);
    end
    if (mem_we1) mem1[off1[3:2]] <= mem_wd1;
    if (busy1) a1_log.push_back(mem_a1);
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic [31:0] seed;
    bit          fen;
    bit          fall;
    logic [5:0]  fw;
    logic [4:0]  fb;
    bit          fv;
    logic [15:0] err;
    logic [31:0] ffa;
    logic [31:0] ffd;
    bit          pass;
  } vec_t;

  // Reference: write pattern, read it back, then the inverse; a stuck bit corrupts reads.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    logic [31:0] word, got;
    r = v;
    r.err = 16'd0; r.ffa = 32'd0; r.ffd = 32'd0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 64; i++) begin
        word = v.seed + 32'(i);
        if (ph == 1) word = ~word;
        got = word;
        if (v.fen && (v.fall || v.fw == 6'(i))) got[v.fb] = v.fv;
        if (got != word) begin
          if (r.err == 16'd0) begin
            r.ffa = 32'(i) * 32'd4;
            r.ffd = got;
          end
          r.err = r.err + 16'd1;
        end
      end
    end
    r.pass = (r.err == 16'd0);
    return r;
  endfunction

  task automatic run0(input vec_t v, input int repulse_at, output int cyc);
    f_en = v.fen; f_all = v.fall; f_word = v.fw; f_bit = v.fb; f_val = v.fv;
    wr_log.delete();
    @(posedge clk); #1;
    seed0 = v.seed; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    cyc = 0;
    while (busy0 && cyc < 2000) begin
      cyc++;
      if (cyc == repulse_at) start0 = 1'b1;
      if (cyc == repulse_at + 3) start0 = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_run(input string nm, input vec_t v, input int cyc);
    chk({nm, "_busy_cycles"}, 32'(cyc), 32'd256);
    chk({nm, "_done"}, 32'(done0), 32'd1);
    chk({nm, "_pass"}, 32'(pass0), 32'(v.pass));
    chk({nm, "_err"}, 32'(err0), 32'(v.err));
    chk({nm, "_ffa"}, ffa0, v.ffa);
    chk({nm, "_ffd"}, ffd0, v.ffd);
  endtask

  vec_t        tbl[7];
  vec_t        v;
  int          cyc, n, bad;
  logic [31:0] a_exp[4];

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; seed0 = 32'd0; seed1 = 32'd0;
    f_en = 1'b0; f_all = 1'b0; f_val = 1'b0; f_word = 6'd0; f_bit = 5'd0;

    // Reset state
    #2;
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_pass", 32'(pass0), 32'd0);
    chk("rst_we", 32'(mem_we0), 32'd0);
    chk("rst_a", mem_a0, 32'd0);
    chk("rst_wd", mem_wd0, 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_ffa", ffa0, 32'd0);
    chk("rst_ffd", ffd0, 32'd0);
    chk("rst_a1", mem_a1, 32'hFFFF_FFF8);
    #20 rst_n = 1'b1;

    // seed, fault_en, all_words, word, bit, stuck_val, err, ffa, ffd, pass
    tbl[0] = '{32'h0000_0000, 0, 0, 6'd0,  5'd0,  0, 16'd0,  32'h00, 32'h0000_0000, 1};
    tbl[1] = '{32'h0000_0001, 1, 0, 6'd5,  5'd0,  0, 16'd1,  32'h14, 32'hFFFF_FFF8, 0};
    tbl[2] = '{32'hA5A5_A5A5, 0, 0, 6'd0,  5'd0,  0, 16'd0,  32'h00, 32'h0000_0000, 1};
    tbl[3] = '{32'h0000_0000, 1, 0, 6'd5,  5'd0,  0, 16'd1,  32'h14, 32'h0000_0004, 0};
    tbl[4] = '{32'h0000_0000, 1, 0, 6'd63, 5'd31, 1, 16'd1,  32'hFC, 32'h8000_003F, 0};
    tbl[5] = '{32'hFFFF_FFFF, 1, 0, 6'd0,  5'd0,  1, 16'd1,  32'h00, 32'h0000_0001, 0};
    tbl[6] = '{32'h0000_0000, 1, 1, 6'd0,  5'd31, 0, 16'd64, 32'h00, 32'h7FFF_FFFF, 0};

    for (int k = 0; k < 7; k++) begin
      run0(tbl[k], -1, cyc);
      check_run($sformatf("vec%0d", k), tbl[k], cyc);
      if (k == 0) begin
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem0[i] !== ~32'(i)) bad++;
        chk("final_mem_inverted", 32'(bad), 32'd0);
        chk("write_count", 32'(wr_log.size()), 32'd128);
        bad = 0;
        foreach (wr_log[i]) if (wr_log[i] !== 32'(i % 64) * 32'd4) bad++;
        chk("write_order", 32'(bad), 32'd0);
      end
    end

    // Randomized runs against the model
    for (int k = 0; k < 6; k++) begin
      v.seed = $urandom;
      v.fen  = ($urandom_range(0, 3) != 0);
      v.fall = ($urandom_range(0, 4) == 0);
      v.fw   = 6'($urandom_range(0, 63));
      v.fb   = 5'($urandom_range(0, 31));
      v.fv   = 1'($urandom_range(0, 1));
      v = model(v);
      run0(v, -1, cyc);
      check_run($sformatf("rnd%0d", k), v, cyc);
    end

    // Word 0 in RD0 after an A5 start
    f_en = 1'b0;
    @(posedge clk); #1;
    seed0 = 32'hA5A5_A5A5; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    chk("a5_cleared_err", 32'(err0), 32'd0);
    chk("a5_pass_while_busy", 32'(pass0), 32'd0);
    repeat (64) @(posedge clk);
    #1;
    chk("a5_rd0_we", 32'(mem_we0), 32'd0);
    chk("a5_rd0_addr", mem_a0, 32'd0);
    chk("a5_rd0_data", mem_rd0, 32'hA5A5_A5A5);
    n = 0;
    while (busy0 && n < 2000) begin n++; @(posedge clk); #1; end
    chk("a5_pass", 32'(pass0), 32'd1);

    // start re-pulsed while busy
    run0(tbl[0], 50, cyc);
    chk("repulse_busy_cycles", 32'(cyc), 32'd256);
    chk("repulse_pass", 32'(pass0), 32'd1);

    // Back-to-back with start held high
    @(posedge clk); #1;
    seed0 = 32'd7; start0 = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!done0 && n < 2000) begin @(posedge clk); #1; n++; end
    chk("b2b_first_len", 32'(n), 32'd256);
    chk("b2b_done_busy", {30'd0, done0, busy0}, 32'd2);
    @(posedge clk); #1;
    chk("b2b_restart", {30'd0, done0, busy0}, 32'd1);
    start0 = 1'b0;
    n = 0;
    while (busy0 && n < 2000) begin n++; @(posedge clk); #1; end
    chk("b2b_second_pass", 32'(pass0), 32'd1);

    // Reset during WR0: write enable must drop without a clock edge
    @(posedge clk); #1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("wr0_we_before_rst", 32'(mem_we0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("wr0_rst_we", 32'(mem_we0), 32'd0);
    chk("wr0_rst_busy", 32'(busy0), 32'd0);
    #2 rst_n = 1'b1;

    // Reset at cycle 100 (inside RD0)
    @(posedge clk); #1;
    seed0 = 32'h1234; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("rd0_busy_before_rst", 32'(busy0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rd0_rst_we", 32'(mem_we0), 32'd0);
    chk("rd0_rst_busy", 32'(busy0), 32'd0);
    chk("rd0_rst_done", 32'(done0), 32'd0);
    chk("rd0_rst_addr", mem_a0, 32'd0);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", {30'd0, done0, busy0}, 32'd0);

    // Wrapping window on the 4-word instance
    a1_log.delete();
    @(posedge clk); #1;
    seed1 = $urandom; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0;
    while (busy1 && n < 200) begin n++; @(posedge clk); #1; end
    chk("wrap_busy_cycles", 32'(n), 32'd16);
    chk("wrap_pass", 32'(pass1), 32'd1);
    chk("wrap_err", 32'(err1), 32'd0);
    chk("wrap_addr_count", 32'(a1_log.size()), 32'd16);
    a_exp[0] = 32'hFFFF_FFF8; a_exp[1] = 32'hFFFF_FFFC; a_exp[2] = 32'h0; a_exp[3] = 32'h4;
    bad = 0;
    foreach (a1_log[i]) if (a1_log[i] !== a_exp[i % 4]) bad++;
    chk("wrap_addr_seq", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
